// File: rtl/frm_seq_ctrl.sv
// Frame sequencer: gates whole frames on cfg_en, shadows geometry at frame start,
// regenerates sof/sol/eol/eof from x/y counters and flags framing errors.
module frm_seq_ctrl #(
  parameter int DATA_WIDTH = 24,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cfg_en,
  input  logic [10:0]           cfg_img_w,
  input  logic [10:0]           cfg_img_h,
  input  logic                  cfg_clr_err,
  input  logic                  m_frm_val,
  output logic                  m_frm_rdy,
  input  logic [DATA_WIDTH-1:0] m_frm_data,
  input  logic                  m_frm_sof,
  input  logic                  m_frm_eof,
  output logic                  s_frm_val,
  input  logic                  s_frm_rdy,
  output logic [DATA_WIDTH-1:0] s_frm_data,
  output logic                  s_frm_sof,
  output logic                  s_frm_eof,
  output logic                  s_frm_sol,
  output logic                  s_frm_eol,
  output logic [10:0]           act_img_w,
  output logic [10:0]           act_img_h,
  output logic                  sts_busy,
  output logic [CNT_WIDTH-1:0]  sts_frm_cnt,
  output logic                  sts_err_sof,
  output logic                  sts_err_eof
);

  typedef enum logic [1:0] {IDLE, WAIT_SOF, ACTIVE} state_t;

  state_t      state, state_nxt;
  logic [10:0] x_q, y_q;
  logic [10:0] cfg_w_cl, cfg_h_cl;
  logic [10:0] w_eff, h_eff, x_eff, y_eff;
  logic        pass, acc, start, frm_end, early_eof;

  assign cfg_w_cl = (cfg_img_w < 11'd2) ? 11'd2 : cfg_img_w;
  assign cfg_h_cl = (cfg_img_h < 11'd2) ? 11'd2 : cfg_img_h;

  // A starting beat is either the first sof after arming or a resync sof mid-frame.
  assign start = m_frm_val & m_frm_sof &
                 ((state == WAIT_SOF) |
                  ((state == ACTIVE) & ((x_q != 11'd0) | (y_q != 11'd0))));

  assign pass       = (state == ACTIVE) | ((state == WAIT_SOF) & m_frm_sof);
  assign m_frm_rdy  = pass ? s_frm_rdy : 1'b1;
  assign s_frm_val  = m_frm_val & pass;
  assign s_frm_data = m_frm_data;
  assign acc        = m_frm_val & m_frm_rdy & pass;

  assign w_eff = start ? cfg_w_cl : act_img_w;
  assign h_eff = start ? cfg_h_cl : act_img_h;
  assign x_eff = start ? 11'd0 : x_q;
  assign y_eff = start ? 11'd0 : y_q;

  assign s_frm_sol = (x_eff == 11'd0);
  assign s_frm_eol = (x_eff == w_eff - 11'd1);
  assign s_frm_sof = s_frm_sol & (y_eff == 11'd0);
  assign s_frm_eof = s_frm_eol & (y_eff == h_eff - 11'd1);

  assign frm_end   = acc & (s_frm_eof | m_frm_eof);
  assign early_eof = acc & m_frm_eof & ~s_frm_eof;
  assign sts_busy  = (state == ACTIVE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Frame end wins over a coincident start so a one-beat frame is still closed out.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (cfg_en) state_nxt = WAIT_SOF;
      end
      WAIT_SOF: begin
        if (frm_end)          state_nxt = cfg_en ? WAIT_SOF : IDLE;
        else if (acc & start) state_nxt = ACTIVE;
        else if (!cfg_en)     state_nxt = IDLE;
      end
      ACTIVE: begin
        if (frm_end) state_nxt = cfg_en ? WAIT_SOF : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q <= 11'd0;
      y_q <= 11'd0;
    end else if (frm_end) begin
      x_q <= 11'd0;
      y_q <= 11'd0;
    end else if (acc & start) begin
      x_q <= 11'd1;
      y_q <= 11'd0;
    end else if (acc) begin
      if (s_frm_eol) begin
        x_q <= 11'd0;
        y_q <= y_q + 11'd1;
      end else begin
        x_q <= x_q + 11'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      act_img_w   <= 11'd2;
      act_img_h   <= 11'd2;
      sts_frm_cnt <= '0;
      sts_err_sof <= 1'b0;
      sts_err_eof <= 1'b0;
    end else begin
      if (acc & start) begin
        act_img_w <= cfg_w_cl;
        act_img_h <= cfg_h_cl;
      end
      if (frm_end) sts_frm_cnt <= sts_frm_cnt + 1'b1;
      sts_err_sof <= (acc & start & (state == ACTIVE)) | (sts_err_sof & ~cfg_clr_err);
      sts_err_eof <= early_eof | (sts_err_eof & ~cfg_clr_err);
    end
  end

endmodule

// File: doc/frm_seq_ctrl.md
Name: frm_seq_ctrl

Overview:
Frame sequencer placed between the AXI-Stream-to-frame converter and the IR filter chain. It gates frames on a software enable, but only at frame boundaries, and latches image geometry into shadow registers at each start of frame. It tracks the pixel x/y position and regenerates clean sof/sol/eol/eof flags from its own counters. It also flags framing errors and counts completed frames.

Parameters:
DATA_WIDTH, 24, pixel data width
CNT_WIDTH, 16, width of the completed-frame counter

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous reset, active low
cfg_en  input  1  stream enable; sampled only at frame boundaries
cfg_img_w  input  11  image width in pixels
cfg_img_h  input  11  image height in lines
cfg_clr_err  input  1  single-cycle pulse; clears sticky error flags
m_frm_val  input  1  upstream beat valid
m_frm_rdy  output  1  upstream beat ready
m_frm_data  input  DATA_WIDTH  upstream pixel
m_frm_sof  input  1  upstream start of frame
m_frm_eof  input  1  upstream end of frame
s_frm_val  output  1  downstream beat valid
s_frm_rdy  input  1  downstream ready
s_frm_data  output  DATA_WIDTH  downstream pixel
s_frm_sof  output  1  regenerated start of frame
s_frm_eof  output  1  regenerated end of frame
s_frm_sol  output  1  regenerated start of line
s_frm_eol  output  1  regenerated end of line
act_img_w  output  11  active (shadow) width; drives the converter's cfg_img_w
act_img_h  output  11  active (shadow) height
sts_busy  output  1  1 while in ACTIVE
sts_frm_cnt  output  CNT_WIDTH  completed frames; wraps at 2^CNT_WIDTH
sts_err_sof  output  1  sticky: sof received mid-frame
sts_err_eof  output  1  sticky: m_frm_eof received before the counted end of frame

Behaviour:
- Reset (async, rst_n=0): state=IDLE, x=0, y=0, act_img_w=2, act_img_h=2, sts_frm_cnt=0, all sts_err_*=0, sts_busy=0.
- Datapath is combinational (0-cycle latency). The only registers are state, counters, shadows and status.
- pass = (state==ACTIVE) | (state==WAIT_SOF & m_frm_sof).
- s_frm_val = m_frm_val & pass.
- m_frm_rdy = pass ? s_frm_rdy : 1. Non-passed beats are dropped (flushed).
- s_frm_data = m_frm_data.
- acc = m_frm_val & m_frm_rdy & pass (accepted beat).
- Shadow load: when a frame starts, act_img_w <= max(cfg_img_w,2) and act_img_h <= max(cfg_img_h,2). W and H below denote the shadow values.
- Flags use the current W,H; on the starting beat they use the incoming cfg values after clamping.
  - s_frm_sol = (x==0)
  - s_frm_eol = (x==W-1)
  - s_frm_sof = (x==0 & y==0)
  - s_frm_eof = (x==W-1 & y==H-1)
- Counter update on acc:
  - If x==W-1: x<=0 and y<=y+1.
  - Otherwise: x<=x+1.
  - At the frame end, x and y are cleared to 0.
- States:
  - IDLE: pass=0, all input is flushed. cfg_en=1 -> WAIT_SOF.
  - WAIT_SOF: flush until m_frm_val & m_frm_sof. That beat passes when s_frm_rdy=1; on acc, load shadows, set x=1, y=0 -> ACTIVE. cfg_en=0 while in WAIT_SOF -> IDLE (no frame in progress).
  - ACTIVE: all beats pass. cfg_en is ignored mid-frame.
- Frame end: acc with s_frm_eof=1, or acc with m_frm_eof=1 (early end).
  - sts_frm_cnt increments by 1.
  - x and y clear to 0.
  - Next state: WAIT_SOF if cfg_en=1, else IDLE.
- Early end: acc with m_frm_eof=1 while not at the counted eof position sets sts_err_eof. The frame still ends and is still counted.
- Mid-frame sof: acc in ACTIVE with m_frm_sof=1 and (x,y)!=(0,0).
  - Sets sts_err_sof.
  - Resyncs: the beat is treated as the first pixel of a new frame. Shadows reload, x=1, y=0. The regenerated flags on that beat use the new shadow: sof=1, sol=1, eol=0.
  - The aborted frame is not counted.
- m_frm_eof coincident with the counted eof position: normal end, no error.
- Error flags: cfg_clr_err clears them. If a set event and cfg_clr_err occur in the same cycle, the set wins.
- cfg_img_w/h changes mid-frame have no effect until the next frame start.
- sts_busy = (state==ACTIVE).

Test Plan:
- Nominal frame: cfg_en=1, W=4, H=3, 12 beats with sof on beat 0 and eof on beat 11, s_frm_rdy=1 -> 12 output beats; sol on beats 0,4,8; eol on beats 3,7,11; sof on beat 0 only; eof on beat 11 only; sts_frm_cnt=1; no errors.
- Pre-sof flush: 5 beats without sof, then a nominal 4x3 frame -> first 5 beats dropped with m_frm_rdy=1 and s_frm_val=0; frame passes intact.
- Backpressure: s_frm_rdy toggling 1/0 every cycle during a 4x3 frame -> counters advance only on acc; flags stay correct; s_frm_data matches the input order.
- Boundary disable: cfg_en dropped at beat 5 of a frame, and cfg_img_w changed to 8 mid-frame -> frame completes with W=4; state goes to IDLE; next frame flushed; act_img_w stays 4.
- Errors: m_frm_eof at beat 6 of a 4x3 frame -> sts_err_eof=1 and sts_frm_cnt increments. Then sof at beat 2 of the next frame -> sts_err_sof=1, resync with x=1; cfg_clr_err clears both flags.
- Async reset asserted mid-frame at beat 7 -> all outputs take their reset values immediately; after release, the sequencer waits for sof.
